// File: rtl/mgmt_gpio_mon_pkg.sv
// rtl/mgmt_gpio_mon_pkg.sv - shared state encoding, fail codes and width helper for the GPIO blink checker
package mgmt_gpio_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RISE = 3'd1,
    ST_HIGH      = 3'd2,
    ST_PASS      = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  typedef logic [2:0] fail_code_t;

  localparam fail_code_t FC_NONE       = 3'd0;
  localparam fail_code_t FC_HIGH_SHORT = 3'd1;
  localparam fail_code_t FC_HIGH_LONG  = 3'd2;
  localparam fail_code_t FC_LOW_SHORT  = 3'd3;
  localparam fail_code_t FC_LOW_LONG   = 3'd4;
  localparam fail_code_t FC_TIMEOUT    = 3'd5;
  localparam fail_code_t FC_DRIVE_LOST = 3'd6;

  // Returns FC_NONE when the width lies inside [lo, hi], else the matching short/long code.
  function automatic fail_code_t width_check(
    input int unsigned width,
    input int unsigned lo,
    input int unsigned hi,
    input fail_code_t  short_code,
    input fail_code_t  long_code
  );
    if (width < lo) begin
      return short_code;
    end
    if (width > hi) begin
      return long_code;
    end
    return FC_NONE;
  endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// rtl/gpio_edge_sync.sv - multi-stage synchronizer with registered-level rise/fall detect
module gpio_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/mgmt_gpio_blink_checker.sv
// rtl/mgmt_gpio_blink_checker.sv - measures mgmt GPIO blink widths and reports sticky pass/fail
module mgmt_gpio_blink_checker
  import mgmt_gpio_mon_pkg::*;
#(
  parameter int unsigned NUM_BLINKS     = 10,
  parameter int unsigned WIDTH_W        = 16,
  parameter int unsigned MIN_WIDTH      = 4,
  parameter int unsigned MAX_WIDTH      = 40000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic               core_clk,
  input  logic               core_rst,
  input  logic               enable,
  input  logic               gpio_out_pad,
  input  logic               gpio_outenb_pad,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic [2:0]         fail_code,
  output logic [7:0]         blink_count,
  output logic               blink_pulse,
  output logic [WIDTH_W-1:0] last_high_width,
  output logic [WIDTH_W-1:0] last_low_width
);

  localparam logic [7:0]         NUM_B     = 8'(NUM_BLINKS);
  localparam logic [WIDTH_W-1:0] CNT_ONE   = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] TIMEOUT_W = WIDTH_W'(TIMEOUT_CYCLES);

  state_t             state_q, state_n;
  fail_code_t         fail_code_q, fail_code_n;
  fail_code_t         width_fc;
  logic [WIDTH_W-1:0] cnt;
  logic               gpio_s, gpio_rise, gpio_fall, any_edge;
  logic               outenb_s, outenb_rise, outenb_fall;
  logic               unused_outenb_edges;
  logic               low_latch, high_latch, blink_done, arm;

  gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_gpio_sync (
    .clk   (core_clk),
    .rst   (core_rst),
    .d     (gpio_out_pad),
    .level (gpio_s),
    .rise  (gpio_rise),
    .fall  (gpio_fall)
  );

  gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_outenb_sync (
    .clk   (core_clk),
    .rst   (core_rst),
    .d     (gpio_outenb_pad),
    .level (outenb_s),
    .rise  (outenb_rise),
    .fall  (outenb_fall)
  );

  // Only the level of the output-enable matters; its edges are not needed.
  assign unused_outenb_edges = outenb_rise ^ outenb_fall;

  assign any_edge = gpio_rise | gpio_fall;
  assign arm      = (state_q == ST_IDLE) && enable;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    fail_code_n = fail_code_q;
    low_latch   = 1'b0;
    high_latch  = 1'b0;
    blink_done  = 1'b0;
    width_fc    = FC_NONE;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          // Drive loss outranks a coincident edge; an edge outranks the timeout.
          if (outenb_s) begin
            state_n     = ST_FAIL;
            fail_code_n = FC_DRIVE_LOST;
          end else if (gpio_rise) begin
            low_latch = 1'b0 | 1'b1;
            if (blink_count != 8'd0) begin
              width_fc = width_check(32'(cnt), MIN_WIDTH, MAX_WIDTH,
                                     FC_LOW_SHORT, FC_LOW_LONG);
            end
            if (width_fc != FC_NONE) begin
              state_n     = ST_FAIL;
              fail_code_n = width_fc;
            end else begin
              state_n = ST_HIGH;
            end
          end else if (!any_edge && cnt == TIMEOUT_W) begin
            state_n     = ST_FAIL;
            fail_code_n = FC_TIMEOUT;
          end
        end
        ST_HIGH: begin
          if (outenb_s) begin
            state_n     = ST_FAIL;
            fail_code_n = FC_DRIVE_LOST;
          end else if (gpio_fall) begin
            high_latch = 1'b1;
            width_fc   = width_check(32'(cnt), MIN_WIDTH, MAX_WIDTH,
                                     FC_HIGH_SHORT, FC_HIGH_LONG);
            if (width_fc != FC_NONE) begin
              state_n     = ST_FAIL;
              fail_code_n = width_fc;
            end else begin
              blink_done = 1'b1;
              state_n    = ((blink_count + 8'd1) == NUM_B) ? ST_PASS : ST_WAIT_RISE;
            end
          end else if (!any_edge && cnt == TIMEOUT_W) begin
            state_n     = ST_FAIL;
            fail_code_n = FC_TIMEOUT;
          end
        end
        default: begin
          state_n = state_q;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == ST_WAIT_RISE) || (state_q == ST_HIGH);
    pass      = (state_q == ST_PASS);
    fail      = (state_q == ST_FAIL);
    fail_code = (state_q == ST_FAIL) ? fail_code_q : FC_NONE;
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      cnt             <= '0;
      fail_code_q     <= FC_NONE;
      blink_count     <= 8'd0;
      blink_pulse     <= 1'b0;
      last_high_width <= '0;
      last_low_width  <= '0;
    end else begin
      blink_pulse <= 1'b0;
      // cnt restarts at 1 after each edge so its value on an edge is the prior level's width.
      if (any_edge || state_q == ST_IDLE) begin
        cnt <= CNT_ONE;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_ONE;
      end
      if (arm) begin
        fail_code_q     <= FC_NONE;
        blink_count     <= 8'd0;
        last_high_width <= '0;
        last_low_width  <= '0;
      end else begin
        fail_code_q <= fail_code_n;
        if (low_latch) begin
          last_low_width <= cnt;
        end
        if (high_latch) begin
          last_high_width <= cnt;
        end
        if (blink_done) begin
          blink_count <= blink_count + 8'd1;
          blink_pulse <= 1'b1;
        end
      end
    end
  end

endmodule
